// File: rtl/keccak_share_ctrl_pkg.sv
// Shared types and constants for the Keccak-f[1600] core sharing controller.
// Requester indices match the wiring order of the sampling modules.
package keccak_share_ctrl_pkg;

  typedef logic [1599:0] keccak_1600_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } keccak_share_state_t;

  localparam int N_KECCAK_REQ = 3;
  localparam int REQ_HASHG    = 0;
  localparam int REQ_XOF      = 1;
  localparam int REQ_PRF      = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keccak_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searched circularly.
module keccak_share_ctrl_rr_pick
  import keccak_share_ctrl_pkg::*;
#(
  parameter int N_REQ = N_KECCAK_REQ,
  parameter int IDX_W = idx_width(N_KECCAK_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from farthest to nearest offset so the nearest requester wins last.
  always_comb begin
    int j;
    j      = 0;
    idx    = '0;
    any    = 1'b0;
    onehot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j   = (int'(ptr) + i) % N_REQ;
      idx = req[j] ? IDX_W'(j) : idx;
      any = any | req[j];
    end
    for (int k = 0; k < N_REQ; k++) begin
      onehot[k] = any & (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/keccak_share_ctrl.sv
// Time-shares one Keccak-f[1600] core among N_REQ requesters with burst-level
// round-robin arbitration, start pulse generation and result capture.
module keccak_share_ctrl
  import keccak_share_ctrl_pkg::*;
#(
  parameter int N_REQ   = N_KECCAK_REQ,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   last_i,
  input  keccak_1600_t       din_i [N_REQ],
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output keccak_1600_t       dout_o,
  output logic               core_start_o,
  output keccak_1600_t       core_din_o,
  input  logic               core_ready_i,
  input  keccak_1600_t       core_dout_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int               IDX_W    = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  keccak_share_state_t state_r;
  logic [IDX_W-1:0]    owner_r;
  logic [IDX_W-1:0]    ptr_r;
  logic                last_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ready_prev_r;
  logic [N_REQ-1:0]    gnt_r;
  logic [N_REQ-1:0]    done_r;
  logic                start_r;
  logic                err_r;
  keccak_1600_t        dout_r;
  keccak_1600_t        core_din_r;

  logic [N_REQ-1:0]    pick_onehot_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic                rise_s;
  logic [IDX_W-1:0]    next_owner_s;

  keccak_share_ctrl_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_i),
    .ptr    (ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign rise_s       = core_ready_i & ~ready_prev_r;
  assign next_owner_s = (owner_r == IDX_MAX) ? '0 : owner_r + IDX_W'(1);

  // Arbitration / permutation sequencing FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      owner_r      <= '0;
      ptr_r        <= '0;
      last_r       <= 1'b0;
      cnt_r        <= '0;
      ready_prev_r <= 1'b0;
      gnt_r        <= '0;
      done_r       <= '0;
      start_r      <= 1'b0;
      err_r        <= 1'b0;
      dout_r       <= '0;
      core_din_r   <= '0;
    end else begin
      ready_prev_r <= core_ready_i;
      done_r       <= '0;
      start_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            owner_r    <= pick_idx_s;
            core_din_r <= din_i[pick_idx_s];
            last_r     <= last_i[pick_idx_s];
            gnt_r      <= pick_onehot_s;
            start_r    <= 1'b1;
            state_r    <= ST_START;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_START: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A Ready already high on entry is not a completion; only a fresh edge counts.
          if (rise_s) begin
            dout_r  <= core_dout_i;
            done_r  <= gnt_r;
            state_r <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            err_r   <= 1'b1;
            gnt_r   <= '0;
            ptr_r   <= next_owner_s;
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (last_r) begin
            gnt_r   <= '0;
            ptr_r   <= next_owner_s;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (req_i[owner_r]) begin
            core_din_r <= din_i[owner_r];
            last_r     <= last_i[owner_r];
            start_r    <= 1'b1;
            state_r    <= ST_START;
          end else begin
            state_r    <= ST_HOLD;
          end
        end
        default: begin
          gnt_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o        = gnt_r;
  assign done_o       = done_r;
  assign dout_o       = dout_r;
  assign core_start_o = start_r;
  assign core_din_o   = core_din_r;
  assign busy_o       = (state_r != ST_IDLE);
  assign err_o        = err_r;

endmodule

// File: tb/tb_keccak_share_ctrl.sv
// Directed self-checking bench for keccak_share_ctrl; the bench plays the
// requesters and the Keccak core.
module tb_keccak_share_ctrl;
  import keccak_share_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int TO = 1023;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, last, gnt, done;
  keccak_1600_t din [N];
  keccak_1600_t dout, core_din, core_dout;
  logic         start, ready, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  keccak_share_ctrl #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(10)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last), .din_i(din),
    .gnt_o(gnt), .done_o(done), .dout_o(dout), .core_start_o(start),
    .core_din_o(core_din), .core_ready_i(ready), .core_dout_i(core_dout),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic keccak_1600_t mk(input logic [63:0] s);
    return {25{s}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({gnt, done, start, busy, err} !== 9'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b", {gnt, done, start, busy, err}, 9'b0); end
    n_checks++; if (dout !== '0) begin n_fail++;
      $display("FAIL reset_dout: got %h expected 0 (low 64b)", dout[63:0]); end
    n_checks++; if (core_din !== '0) begin n_fail++;
      $display("FAIL reset_core_din: got %h expected 0 (low 64b)", core_din[63:0]); end
  endtask

  task automatic test_single();
    keccak_1600_t d0, r;
    logic seen;
    d0 = mk(64'h1111_2222_3333_4444);
    r  = mk(64'hA5A5_0000_FFFF_1234);
    req = 3'b001; last = 3'b001; din[0] = d0;
    tick();  // START
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt: got %b expected %b", gnt, 3'b001); end
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", start); end
    n_checks++; if (core_din !== d0) begin n_fail++;
      $display("FAIL single_core_din: got %h expected %h (low 64b)", core_din[63:0], d0[63:0]); end
    req = 3'b000;
    tick();  // first WAIT cycle
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b expected 0", start); end
    seen = 1'b0;
    repeat (23) begin
      if (done !== 3'b000) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %b expected 0", seen); end
    ready = 1'b1; core_dout = r;
    tick();  // DONE
    n_checks++; if (done !== 3'b001) begin n_fail++; $display("FAIL single_done: got %b expected %b", done, 3'b001); end
    n_checks++; if (dout !== r) begin n_fail++;
      $display("FAIL single_dout: got %h expected %h (low 64b)", dout[63:0], r[63:0]); end
    ready = 1'b0; core_dout = mk(64'hDEAD_BEEF_0000_0000);
    tick();  // IDLE
    n_checks++; if ({gnt, busy, done} !== 7'b0) begin n_fail++;
      $display("FAIL single_release: got %b expected %b", {gnt, busy, done}, 7'b0); end
    n_checks++; if (dout !== r) begin n_fail++;
      $display("FAIL single_dout_hold: got %h expected %h (low 64b)", dout[63:0], r[63:0]); end
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] exp_gnt [4];
    int           exp_idx [4];
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_idx = '{0, 1, 2, 0};
    do_reset();
    for (int i = 0; i < N; i++) din[i] = mk(64'h0100_0000_0000_0000 * (i + 1) + 64'(i));
    req = 3'b111; last = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();  // START
      n_checks++; if (gnt !== exp_gnt[k]) begin n_fail++;
        $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, exp_gnt[k]); end
      n_checks++; if (core_din !== din[exp_idx[k]]) begin n_fail++;
        $display("FAIL rr_core_din%0d: got %h expected %h (low 64b)", k, core_din[63:0], din[exp_idx[k]][63:0]); end
      tick();  // WAIT
      ready = 1'b1; core_dout = mk(64'(k + 100));
      tick();  // DONE
      n_checks++; if (done !== exp_gnt[k]) begin n_fail++;
        $display("FAIL rr_done%0d: got %b expected %b", k, done, exp_gnt[k]); end
      ready = 1'b0;
      if (k == 3) req = 3'b000;
      tick();  // IDLE gap between bursts
      n_checks++; if (gnt !== 3'b000) begin n_fail++;
        $display("FAIL rr_idle_gap%0d: got %b expected %b", k, gnt, 3'b000); end
    end
  endtask

  task automatic test_burst();
    keccak_1600_t d2;
    do_reset();
    req = 3'b110; last = 3'b000; din[1] = mk(64'hB0B0_0000_0000_0001);
    tick();  // START, owner 1
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL burst_gnt: got %b expected %b", gnt, 3'b010); end
    req = 3'b100;
    tick(); ready = 1'b1;
    tick();  // DONE
    n_checks++; if (done !== 3'b010) begin n_fail++; $display("FAIL burst_done0: got %b expected %b", done, 3'b010); end
    ready = 1'b0;
    tick();  // HOLD
    n_checks++; if ({gnt, start} !== 4'b0100) begin n_fail++;
      $display("FAIL burst_hold0: got %b expected %b", {gnt, start}, 4'b0100); end
    tick();  // still HOLD despite req 2
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL burst_hold1: got %b expected %b", gnt, 3'b010); end
    for (int p = 1; p <= 2; p++) begin
      req = 3'b110; last = (p == 2) ? 3'b010 : 3'b000;
      din[1] = mk(64'hB0B0_0000_0000_0000 + 64'(p) + 64'h10);
      tick();  // START
      n_checks++; if ({start, core_din} !== {1'b1, din[1]}) begin n_fail++;
        $display("FAIL burst_restart%0d: got %b/%h expected 1/%h", p, start, core_din[63:0], din[1][63:0]); end
      req = 3'b100;
      tick(); ready = 1'b1;
      tick();  // DONE
      n_checks++; if (done !== 3'b010) begin n_fail++;
        $display("FAIL burst_done%0d: got %b expected %b", p, done, 3'b010); end
      ready = 1'b0;
      tick();
    end
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL burst_release: got %b expected %b", gnt, 3'b000); end
    d2 = mk(64'hC2C2_C2C2_0000_0002);
    req = 3'b101; last = 3'b101; din[2] = d2;
    tick();  // START: ptr must now be 2
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL burst_ptr2: got %b expected %b", gnt, 3'b100); end
    n_checks++; if (core_din !== d2) begin n_fail++;
      $display("FAIL burst_core_din2: got %h expected %h (low 64b)", core_din[63:0], d2[63:0]); end
  endtask

  task automatic test_reset_mid_wait();
    tick();  // WAIT with owner 2
    rst = 1'b1;
    tick();
    n_checks++; if ({gnt, done, start, busy, err} !== 9'b0) begin n_fail++;
      $display("FAIL rstwait_ctrl: got %b expected %b", {gnt, done, start, busy, err}, 9'b0); end
    n_checks++; if ({dout, core_din} !== '0) begin n_fail++;
      $display("FAIL rstwait_data: got %h/%h expected 0/0 (low 64b)", dout[63:0], core_din[63:0]); end
    rst = 1'b0; req = 3'b000;
    tick(); ready = 1'b1;
    tick(); ready = 1'b0;
    n_checks++; if ({done, busy} !== 4'b0) begin n_fail++;
      $display("FAIL rstwait_no_done: got %b expected %b", {done, busy}, 4'b0); end
    req = 3'b110; last = 3'b110;
    tick();  // ptr back at 0 so requester 1 wins
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rstwait_ptr0: got %b expected %b", gnt, 3'b010); end
    req = 3'b000;
    tick(); ready = 1'b1;
    tick(); ready = 1'b0;
    tick();
  endtask

  task automatic test_ready_stuck();
    logic seen;
    do_reset();
    ready = 1'b1;
    tick();
    req = 3'b011; last = 3'b011;
    tick();  // START, owner 0
    tick();  // WAIT cycle 1
    seen = 1'b0;
    repeat (TO - 1) begin
      if (done !== 3'b000) seen = 1'b1;
      tick();
    end
    n_checks++; if ({seen, err, gnt} !== 5'b00001) begin n_fail++;
      $display("FAIL stuck_before_timeout: got %b expected %b", {seen, err, gnt}, 5'b00001); end
    tick();  // watchdog fired
    n_checks++; if ({err, gnt, done, busy} !== 8'b1000_0000) begin n_fail++;
      $display("FAIL stuck_timeout: got %b expected %b", {err, gnt, done, busy}, 8'b1000_0000); end
    ready = 1'b0;
    tick();  // ptr moved past owner 0
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL stuck_ptr: got %b expected %b", gnt, 3'b010); end
    req = 3'b000;
    tick(); ready = 1'b1;
    tick();
    n_checks++; if ({done, err} !== 4'b0101) begin n_fail++;
      $display("FAIL stuck_err_sticky: got %b expected %b", {done, err}, 4'b0101); end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_input_stability();
    keccak_1600_t a;
    a = mk(64'h0F0F_1234_5678_9ABC);
    do_reset();
    req = 3'b001; last = 3'b001; din[0] = a;
    tick();
    din[0] = mk(64'hFFFF_EEEE_DDDD_CCCC); req = 3'b000;
    tick(); tick();
    n_checks++; if (core_din !== a) begin n_fail++;
      $display("FAIL stable_wait: got %h expected %h (low 64b)", core_din[63:0], a[63:0]); end
    ready = 1'b1;
    tick();
    n_checks++; if ({done, core_din} !== {3'b001, a}) begin n_fail++;
      $display("FAIL stable_done: got %b/%h expected 001/%h", done, core_din[63:0], a[63:0]); end
    ready = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; ready = 1'b0; core_dout = '0;
    for (int i = 0; i < N; i++) din[i] = '0;
    tick(); tick(); tick();
    test_reset();
    test_single();
    test_rr_fairness();
    test_burst();
    test_reset_mid_wait();
    test_ready_stuck();
    test_input_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_share_ctrl.md
Name: keccak_share_ctrl

Overview:
- Time-shares one Keccak-f[1600] permutation core among N_REQ requesters: hash_G (SHA3-512), sampleA XOF (SHAKE128) and sampleCBD PRF (SHAKE256).
- Round-robin arbitration at burst granularity. A burst is one or more permutations; the grant is held until the owner flags the last permutation.
- Generates the core start pulse and muxes/holds core input.
- Detects the core Ready rising edge and returns a done pulse plus a registered 1600-bit result.
- Sits between the keygen/encap/decap sequencers' sampling modules and the single keccak_top instance.

Parameters:
- N_REQ, 3, number of requesters (index 0 = hash_G, 1 = XOF, 2 = PRF).
- TIMEOUT, 1023, maximum cycles in WAIT before a watchdog abort.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  N_REQ  per-requester permutation request (level)
- last_i  in  N_REQ  sampled with req_i; 1 = this permutation ends the burst
- din_i  in  N_REQ x keccak_1600_t  per-requester state input, valid whenever req_i is high
- gnt_o  out  N_REQ  one-hot burst ownership
- done_o  out  N_REQ  1-cycle pulse to the owner, result valid
- dout_o  out  keccak_1600_t  registered result, held until the next capture
- core_start_o  out  1  1-cycle start pulse, drives keccak_top Reset
- core_din_o  out  keccak_1600_t  registered core input
- core_ready_i  in  1  keccak_top Ready
- core_dout_i  in  keccak_1600_t  keccak_top OutData
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky watchdog flag; cleared only by rst_i

Behaviour:
Reset (rst_i = 1 at a clock edge):
- State goes to IDLE.
- gnt_o, done_o, core_start_o, busy_o and err_o are 0; dout_o and core_din_o are 0.
- RR pointer is 0; ready_prev is 0.
- Reset mid-burst aborts silently. Core Ready edges seen after reset outside WAIT are ignored.

States: IDLE, START, WAIT, DONE, HOLD. All outputs are registered or Moore.

IDLE:
- If any req_i bit is set, the winner is the first set bit at or after ptr, circularly.
- At that edge: owner <= winner, core_din_o <= din_i[winner], last_q <= last_i[winner]. Next state is START.
- Request seen at cycle t gives gnt_o[owner] = 1 and core_start_o = 1 at t+1.

START:
- core_start_o = 1 for exactly this one cycle.
- Clear the watchdog counter; next state is WAIT.

WAIT:
- Rising-edge detect: rise = core_ready_i & !ready_prev. ready_prev is updated every cycle.
- On rise at cycle t_r: dout_o <= core_dout_i, next state is DONE. done_o[owner] = 1 at t_r+1.
- If the counter reaches TIMEOUT: set err_o, drop the grant, ptr <= owner+1, go to IDLE with no done pulse.

DONE (one cycle):
- If last_q = 1: release the burst. ptr <= (owner+1) mod N_REQ, gnt_o <= 0, next state is IDLE.
- Otherwise go to HOLD; gnt_o stays set.

HOLD:
- Only req_i[owner] is honoured; other requesters wait regardless of priority.
- On req_i[owner]: reload core_din_o and last_q from the owner, then go to START.

Throughput and timing:
- At least one IDLE cycle separates bursts of different owners.
- Back-to-back permutations by the same owner cost 2 cycles of overhead: DONE then HOLD to START.
- Requesters must keep req_i high until gnt_o. Within a burst, pulse req_i once per permutation, only after the matching done_o.

Simultaneous events and width rules:
- Requests arriving while state != IDLE are queued implicitly (level), not lost.
- A requester deasserting before grant is simply not selected.
- ptr wraps from N_REQ-1 to 0. gnt_o and done_o are always one-hot or zero.

Decomposition:
- TYPES_KEM package gains:
  - keccak_share_state_t (enum, 3 bits).
  - Constants N_KECCAK_REQ = 3, REQ_HASHG = 0, REQ_XOF = 1, REQ_PRF = 2.
  - Reuse of the existing keccak_1600_t.
- One sub-module, rr_pick: combinational round-robin selector. Inputs are the request vector and ptr; outputs are the one-hot winner, its index and an any flag.

Test Plan:
1. Single request: req_i = 3'b001 with last = 1 at cycle 5. Expect gnt_o = 001 and core_start_o at cycle 6. Core Ready rises at cycle 30, so done_o = 001 and dout_o = core_dout_i at cycle 31. gnt_o = 0 and busy_o = 0 at cycle 32.
2. Contention, RR fairness: req_i = 3'b111 held, all last = 1, ptr = 0. Grant order must be 0, 1, 2, 0.
3. Multi-permutation burst: requester 1 issues 3 permutations (last = 0, 0, 1) while req 2 is held high. Requester 2 is granted only after the third done_o, and ptr then equals 2.
4. Ready stuck high at start: core_ready_i = 1 before START and kept high. No done_o until a low-to-high transition occurs. With TIMEOUT = 15 this gives err_o = 1 and grant release after 15 WAIT cycles.
5. Reset mid-WAIT: assert rst_i for 1 cycle while owner = 2. Next cycle all outputs are 0 and ptr = 0. A later core Ready edge produces no done_o.
6. Input stability: change din_i[0] after grant. core_din_o must hold the value captured at arbitration.
